// File: rtl/spi_loader_if.sv
// -----------------------------------------------------------------------------
// spi_loader_if
// Bundles the connection between the flash loader (which owns the SPI master's
// command side) and the shared `spi` master instance.
//
// Signals:
//   spi_start    loader -> spi : byte start request, held until spi_busy seen
//   spi_data_tx  loader -> spi : byte to shift out on MOSI
//   spi_cs       loader -> spi : chip select, active low
//   spi_busy     spi -> loader : byte transfer in progress
//   spi_data_rx  spi -> loader : byte shifted in on MISO, valid when busy falls
//
// Modports:
//   master : the side that issues bytes (spi_loader)
//   slave  : the side that executes them (spi master / bench model)
// -----------------------------------------------------------------------------
interface spi_loader_if;
  logic       spi_start;
  logic [7:0] spi_data_tx;
  logic       spi_cs;
  logic       spi_busy;
  logic [7:0] spi_data_rx;

  modport master (
    output spi_start, spi_data_tx, spi_cs,
    input  spi_busy, spi_data_rx
  );

  modport slave (
    input  spi_start, spi_data_tx, spi_cs,
    output spi_busy, spi_data_rx
  );
endinterface

// File: rtl/spi_loader.sv
// -----------------------------------------------------------------------------
// spi_loader
// Streams a block of bytes from SPI flash (READ 0x03 + 24-bit address) into a
// memory write port, and arbitrates the shared SPI master between the CPU-side
// peripheral registers and this loader. Outside a load the CPU controls pass
// straight through; while a load is pending or running the loader owns the bus
// and CPU requests are ignored.
//
// Optional build macro: SPI_LOADER_CHECKSUM_EN
//   When defined, adds output `checksum`: sum modulo 256 of the bytes written
//   by the current/last load (cleared on request latch, valid at `done`).
//
// Ports:
//   raw_clk, reset           clock, synchronous active-high reset
//   start                    one-cycle load request (ignored while busy)
//   flash_address/length/    load parameters, sampled when the request is
//   mem_base                 latched; length 0 completes without SPI activity
//   busy, done               load pending/running; one-cycle completion pulse
//   load_count               bits [15:8] of bytes written (256-byte pages)
//   mem_address/mem_data/    memory write port, one write per byte
//   mem_write_enable
//   cpu_spi_start/tx/cs      CPU-side SPI controls (passed through when idle)
//   cpu_spi_busy             spi_busy | busy, as seen by the CPU
//   spi                      connection to the SPI master (master modport)
//   checksum                 (SPI_LOADER_CHECKSUM_EN only) byte sum mod 256
// -----------------------------------------------------------------------------
module spi_loader #(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      raw_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [23:0]               flash_address,
  input  logic [15:0]               length,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_base,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                load_count,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]                mem_data,
  output logic                      mem_write_enable,
  input  logic                      cpu_spi_start,
  input  logic [7:0]                cpu_spi_tx,
  input  logic                      cpu_spi_cs,
  output logic                      cpu_spi_busy,
`ifdef SPI_LOADER_CHECKSUM_EN
  output logic [7:0]                checksum,
`endif
  spi_loader_if.master              spi
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_LOW, S_CMD, S_ADDR2, S_ADDR1, S_ADDR0,
    S_DATA, S_WRITE, S_CS_HIGH, S_DONE
  } state_t;

  state_t                    state_q;
  logic                      pending_q;
  logic                      phase_q;     // 0: waiting for busy to rise, 1: waiting for it to fall
  logic                      start_q;
  logic                      cs_q;
  logic [23:0]               addr_q;
  logic [15:0]               len_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [15:0]               index_q;
  logic [15:0]               index_d;
  logic [7:0]                rx_q;
  logic [7:0]                load_count_q;
  logic [7:0]                ld_tx;
  logic                      cpu_owns;
`ifdef SPI_LOADER_CHECKSUM_EN
  logic [7:0]                checksum_q;
`endif

  assign index_d = index_q + 16'd1;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      phase_q      <= 1'b0;
      start_q      <= 1'b0;
      cs_q         <= 1'b1;
      index_q      <= 16'd0;
      load_count_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!pending_q) begin
            if (start) begin
              pending_q    <= 1'b1;
              addr_q       <= flash_address;
              len_q        <= length;
              base_q       <= mem_base;
              index_q      <= 16'd0;
              load_count_q <= 8'd0;
`ifdef SPI_LOADER_CHECKSUM_EN
              checksum_q   <= 8'd0;
`endif
            end
          end else if (len_q == 16'd0) begin
            pending_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (!spi.spi_busy && !cpu_spi_start) begin
            // Only take the bus once no CPU byte is in flight or being launched.
            pending_q <= 1'b0;
            cs_q      <= 1'b0;
            state_q   <= S_CS_LOW;
          end
        end
        S_CS_LOW: begin
          state_q <= S_CMD;
          start_q <= 1'b1;
          phase_q <= 1'b0;
        end
        S_CMD, S_ADDR2, S_ADDR1, S_ADDR0, S_DATA: begin
          if (!phase_q) begin
            if (spi.spi_busy) begin
              start_q <= 1'b0;
              phase_q <= 1'b1;
            end
          end else if (!spi.spi_busy) begin
            phase_q <= 1'b0;
            case (state_q)
              S_CMD:   begin state_q <= S_ADDR2; start_q <= 1'b1; end
              S_ADDR2: begin state_q <= S_ADDR1; start_q <= 1'b1; end
              S_ADDR1: begin state_q <= S_ADDR0; start_q <= 1'b1; end
              S_ADDR0: begin state_q <= S_DATA;  start_q <= 1'b1; end
              S_DATA:  begin state_q <= S_WRITE; rx_q <= spi.spi_data_rx; end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          index_q      <= index_d;
          load_count_q <= index_d[15:8];
`ifdef SPI_LOADER_CHECKSUM_EN
          checksum_q   <= checksum_q + rx_q;
`endif
          if (index_d == len_q) begin
            cs_q    <= 1'b1;
            state_q <= S_CS_HIGH;
          end else begin
            start_q <= 1'b1;
            state_q <= S_DATA;
          end
        end
        S_CS_HIGH: state_q <= S_DONE;
        S_DONE:    state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // Byte presented to the SPI master in each byte state.
  always_comb begin
    ld_tx = 8'h00;
    case (state_q)
      S_CMD:   ld_tx = 8'h03;
      S_ADDR2: ld_tx = addr_q[23:16];
      S_ADDR1: ld_tx = addr_q[15:8];
      S_ADDR0: ld_tx = addr_q[7:0];
      default: ld_tx = 8'h00;
    endcase
  end

  // The CPU owns the SPI master only when the loader is idle with nothing queued.
  assign cpu_owns        = (state_q == S_IDLE) && !pending_q;
  assign spi.spi_start   = cpu_owns ? cpu_spi_start : start_q;
  assign spi.spi_data_tx = cpu_owns ? cpu_spi_tx    : ld_tx;
  assign spi.spi_cs      = cpu_owns ? cpu_spi_cs    : cs_q;

  assign busy             = !cpu_owns;
  assign done             = (state_q == S_DONE);
  assign cpu_spi_busy     = spi.spi_busy | busy;
  assign load_count       = load_count_q;
  assign mem_write_enable = (state_q == S_WRITE);
  assign mem_address      = base_q + MEM_ADDR_WIDTH'(index_q);
  assign mem_data         = rx_q;
`ifdef SPI_LOADER_CHECKSUM_EN
  assign checksum         = checksum_q;
`endif

endmodule

// File: tb/tb_spi_loader.sv
module tb_spi_loader;

  logic        raw_clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] flash_address;
  logic [15:0] length;
  logic [15:0] mem_base;
  logic        busy;
  logic        done;
  logic [7:0]  load_count;
  logic [15:0] mem_address;
  logic [7:0]  mem_data;
  logic        mem_write_enable;
  logic        cpu_spi_start;
  logic [7:0]  cpu_spi_tx;
  logic        cpu_spi_cs;
  logic        cpu_spi_busy;
`ifdef SPI_LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  always #5 raw_clk = ~raw_clk;

  spi_loader_if bus();

  spi_loader #(.MEM_ADDR_WIDTH(16)) dut (
    .raw_clk          (raw_clk),
    .reset            (reset),
    .start            (start),
    .flash_address    (flash_address),
    .length           (length),
    .mem_base         (mem_base),
    .busy             (busy),
    .done             (done),
    .load_count       (load_count),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .cpu_spi_start    (cpu_spi_start),
    .cpu_spi_tx       (cpu_spi_tx),
    .cpu_spi_cs       (cpu_spi_cs),
    .cpu_spi_busy     (cpu_spi_busy),
`ifdef SPI_LOADER_CHECKSUM_EN
    .checksum         (checksum),
`endif
    .spi              (bus)
  );

  // SPI master + flash model: each byte is busy for 3 cycles; bytes inside a
  // CS-low frame are logged, and frame byte j >= 4 returns 0x10 + (j - 4).
  logic       m_busy = 1'b0;
  logic [7:0] m_rx   = 8'h00;
  int         m_cnt = 0, m_cur = 0, m_n = 0, m_frame_n = 0;
  logic [7:0] mosi_log [16];

  assign bus.spi_busy    = m_busy;
  assign bus.spi_data_rx = m_rx;

  always @(negedge raw_clk) begin
    if (bus.spi_cs) begin
      if (m_n != 0) m_frame_n = m_n;
      m_n = 0;
    end
    if (m_busy) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_rx   = 8'h10 + 8'(m_cur - 4);
      end
    end else if (bus.spi_start) begin
      m_cur = m_n;
      if (!bus.spi_cs) begin
        if (m_n < 16) mosi_log[m_n] = bus.spi_data_tx;
        m_n = m_n + 1;
      end
      m_busy = 1'b1;
      m_cnt  = 3;
    end
  end

  // Memory-port / progress monitor.
  int          w_total = 0, w_b2b = 0, done_total = 0, lc_n = 0;
  logic        prev_we = 1'b0;
  logic [7:0]  prev_lc = 8'h00;
  logic [15:0] wa_log [1024];
  logic [7:0]  wd_log [1024];
  logic [7:0]  lc_log [16];

  always @(negedge raw_clk) begin
    if (mem_write_enable === 1'b1) begin
      wa_log[w_total % 1024] = mem_address;
      wd_log[w_total % 1024] = mem_data;
      if (prev_we) w_b2b = w_b2b + 1;
      w_total = w_total + 1;
    end
    prev_we = (mem_write_enable === 1'b1);
    if (done === 1'b1) done_total = done_total + 1;
    if (load_count !== prev_lc) begin
      if (lc_n < 16) lc_log[lc_n] = load_count;
      lc_n = lc_n + 1;
    end
    prev_lc = load_count;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge raw_clk);
      #2;
    end
  endtask

  task automatic run_load(input logic [23:0] a, input logic [15:0] len, input logic [15:0] base);
    flash_address = a;
    length        = len;
    mem_base      = base;
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic wait_spi_idle(input string tag);
    int n = 0;
    while (bus.spi_busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_spi_idle"}, bus.spi_busy, 1'b0);
  endtask

  logic [7:0] exp_basic [8] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] exp_def   [6] = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};

  initial begin
    int w0, d0, l0, n;
    reset = 1'b1; start = 1'b0; flash_address = '0; length = '0; mem_base = '0;
    cpu_spi_start = 1'b0; cpu_spi_tx = 8'h00; cpu_spi_cs = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_we", mem_write_enable, 1'b0);
    check("rst_load_count", load_count, 8'h00);
    check("rst_cs", bus.spi_cs, 1'b1);
    check("rst_start", bus.spi_start, 1'b0);

    // Idle pass-through
    cpu_spi_start = 1'b1; cpu_spi_tx = 8'hA5; cpu_spi_cs = 1'b0;
    #1;
    check("pt_start", bus.spi_start, 1'b1);
    check("pt_tx", bus.spi_data_tx, 8'hA5);
    check("pt_cs", bus.spi_cs, 1'b0);
    check("pt_busy", busy, 1'b0);
    tick();
    cpu_spi_start = 1'b0;
    check("pt_cpu_busy", cpu_spi_busy, 1'b1);
    wait_spi_idle("pt");
    cpu_spi_cs = 1'b1;
    tick();

    // Basic load
    w0 = w_total; d0 = done_total;
    run_load(24'h012345, 16'd4, 16'h1000);
    check("basic_busy", busy, 1'b1);
    check("basic_cpu_busy", cpu_spi_busy, 1'b1);
    wait_done("basic", 400);
    for (int i = 0; i < 8; i++)
      check($sformatf("basic_mosi%0d", i), mosi_log[i], exp_basic[i]);
    check("basic_nbytes", m_frame_n, 8);
    check("basic_nwrites", w_total - w0, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_waddr%0d", i), wa_log[(w0 + i) % 1024], 16'h1000 + 16'(i));
      check($sformatf("basic_wdata%0d", i), wd_log[(w0 + i) % 1024], 8'h10 + 8'(i));
    end
`ifdef SPI_LOADER_CHECKSUM_EN
    check("basic_checksum", checksum, 8'h46);
`endif
    tick();
    check("basic_busy_after", busy, 1'b0);
    check("basic_done_after", done, 1'b0);
    check("basic_done_count", done_total - d0, 1);

    // Deferral behind an in-flight CPU byte
    cpu_spi_cs = 1'b0; cpu_spi_start = 1'b1; cpu_spi_tx = 8'h5A;
    tick();
    cpu_spi_start = 1'b0;
    check("def_cpu_inflight", bus.spi_busy, 1'b1);
    w0 = w_total;
    run_load(24'h000100, 16'd2, 16'h2000);
    check("def_busy", busy, 1'b1);
    check("def_cs_held1", bus.spi_cs, 1'b1);
    check("def_still_inflight", bus.spi_busy, 1'b1);
    tick();
    check("def_cs_held2", bus.spi_cs, 1'b1);
    tick(3);
    cpu_spi_start = 1'b1; cpu_spi_tx = 8'hEE;
    wait_done("def", 400);
    check("def_nbytes", m_frame_n, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("def_mosi%0d", i), mosi_log[i], exp_def[i]);
    check("def_nwrites", w_total - w0, 2);
    check("def_waddr1", wa_log[(w0 + 1) % 1024], 16'h2001);
    check("def_wdata1", wd_log[(w0 + 1) % 1024], 8'h11);
    tick();
    check("def_pt_start", bus.spi_start, 1'b1);
    check("def_pt_tx", bus.spi_data_tx, 8'hEE);
    check("def_pt_cs", bus.spi_cs, 1'b0);
    cpu_spi_start = 1'b0;
    tick();
    cpu_spi_cs = 1'b1;
    wait_spi_idle("def");
    tick();

    // Zero length
    w0 = w_total; d0 = done_total;
    run_load(24'h000000, 16'd0, 16'h4000);
    check("zero_busy", busy, 1'b1);
    check("zero_done_early", done, 1'b0);
    check("zero_cs1", bus.spi_cs, 1'b1);
    tick();
    check("zero_done", done, 1'b1);
    check("zero_cs2", bus.spi_cs, 1'b1);
    tick();
    check("zero_done_end", done, 1'b0);
    check("zero_busy_end", busy, 1'b0);
    check("zero_nwrites", w_total - w0, 0);
    check("zero_done_count", done_total - d0, 1);

    // Progress and address wrap
    w0 = w_total; l0 = lc_n;
    run_load(24'h000000, 16'h0300, 16'hFF80);
    wait_done("wrap", 20000);
    check("wrap_nwrites", w_total - w0, 768);
    check("wrap_first_addr", wa_log[w0 % 1024], 16'hFF80);
    check("wrap_last_addr", wa_log[(w0 + 767) % 1024], 16'h027F);
    check("wrap_load_count", load_count, 8'h03);
    check("wrap_lc_steps", lc_n - l0, 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("wrap_lc_step%0d", i), lc_log[(l0 + i) % 16], 8'(i + 1));
    check("wrap_no_b2b_we", w_b2b, 0);
    tick();

    // Reset in the middle of a load (ADDR1 byte)
    w0 = w_total;
    run_load(24'h012345, 16'd4, 16'h3000);
    n = 0;
    while (!(bus.spi_start === 1'b1 && bus.spi_data_tx === 8'h23) && n < 100) begin
      tick();
      n++;
    end
    check("rm_reach_addr1", {bus.spi_start, bus.spi_data_tx}, {1'b1, 8'h23});
    reset = 1'b1;
    tick();
    check("rm_busy", busy, 1'b0);
    check("rm_cs", bus.spi_cs, 1'b1);
    check("rm_start", bus.spi_start, 1'b0);
    check("rm_load_count", load_count, 8'h00);
    reset = 1'b0;
    wait_spi_idle("rm");
    check("rm_nwrites_none", w_total - w0, 0);
    run_load(24'h012345, 16'd4, 16'h3000);
    wait_done("rm_again", 400);
    check("rm_again_nwrites", w_total - w0, 4);
    check("rm_again_last_addr", wa_log[(w0 + 3) % 1024], 16'h3003);
    check("rm_again_last_data", wd_log[(w0 + 3) % 1024], 8'h13);
    check("rm_again_nbytes", m_frame_n, 8);
    tick();
    check("rm_again_busy_after", busy, 1'b0);
    check("no_b2b_we_total", w_b2b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_loader.md
# spi_loader

Sequencer that owns the shared SPI master and streams a block of bytes from external SPI flash (READ 0x03, 24-bit address) into memory. It also arbitrates the SPI master between itself and the CPU-side peripheral registers. Outside a load, CPU requests pass straight through; during a load, CPU requests are blocked. It sits between the peripheral register file, the `spi` instance and the memory write port, and reports progress through `load_count`.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, 16, width of the memory write address.

Ports:
- `raw_clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle load request.
- `flash_address` in 24: first flash byte; sampled when the request is latched.
- `length` in 16: byte count; 0 means no transfer. Sampled with `flash_address`.
- `mem_base` in MEM_ADDR_WIDTH: destination of the first byte; sampled with `flash_address`.
- `busy` out 1: load in progress, including pending.
- `done` out 1: one-cycle completion pulse.
- `load_count` out 8: bits [15:8] of bytes written so far, i.e. progress in 256-byte pages.
- `mem_address` out MEM_ADDR_WIDTH, `mem_data` out 8, `mem_write_enable` out 1: memory write port.
- `cpu_spi_start` in 1, `cpu_spi_tx` in 8, `cpu_spi_cs` in 1: CPU-side SPI controls.
- `cpu_spi_busy` out 1: `spi_busy | busy`.
- `spi_start` out 1, `spi_data_tx` out 8, `spi_cs` out 1, `spi_busy` in 1, `spi_data_rx` in 8: connections to the `spi` master.

## Operation
- **SPI ownership mux (combinational).**
  - State IDLE, nothing pending: `spi_start = cpu_spi_start`, `spi_data_tx = cpu_spi_tx`, `spi_cs = cpu_spi_cs`.
  - Otherwise the loader drives all three, and the CPU inputs are ignored.
- **Request latching.** `start` in IDLE latches `flash_address`, `length` and `mem_base`, and sets `pending`. `start` while `busy` is ignored.
- **Pending to start.** Leave IDLE only when `pending`, `spi_busy == 0` and `cpu_spi_start == 0`. This prevents cutting off a CPU byte.
- **States:**
  - IDLE.
  - CS_LOW: drive `spi_cs = 0` for one cycle.
  - CMD: byte 0x03.
  - ADDR2, ADDR1, ADDR0: `flash_address` bits [23:16], [15:8], [7:0].
  - DATA: transmit 0x00 and capture `spi_data_rx`.
  - WRITE.
  - CS_HIGH.
  - DONE, then back to IDLE.
- **Byte sub-handshake (every byte state).**
  - Phase A: `spi_start = 1` with `spi_data_tx` valid until `spi_busy == 1` is sampled.
  - Phase B: `spi_start = 0`; wait for `spi_busy == 0`.
  - Phase B then exits: the current byte is done (captured, in DATA).
- **WRITE.**
  - For one cycle: `mem_write_enable = 1`, `mem_address = mem_base + index`, `mem_data = captured byte`. Address arithmetic wraps modulo 2^MEM_ADDR_WIDTH.
  - Then `index` increments (16-bit). If `index == length`, go to CS_HIGH; otherwise go to DATA.
- **`length == 0`.** Go IDLE → DONE directly. No CS activity, no writes.
- **`spi_cs`.** Held 0 from CS_LOW through the last WRITE. Set to 1 in CS_HIGH and held for one cycle before DONE.
- **`load_count`.** Cleared when a request is latched. Tracks `index[15:8]` after each write, and holds its final value after DONE until the next request.

## Timing
- **Reset values:** state IDLE, `pending = 0`, `busy = 0`, `done = 0`, `mem_write_enable = 0`, `load_count = 0`, loader-driven `spi_cs = 1`, loader-driven `spi_start = 0`.
- **`reset` mid-load:** next cycle the block is in IDLE with CS released. Memory writes already made are kept.
- **`busy`:** high from the cycle after `start` is accepted through the DONE cycle inclusive.
- **`done`:** high only in the DONE cycle. On the following cycle `busy = 0` and CPU pass-through resumes.
- **Minimum per byte:** 1 cycle of `spi_start`, plus the SPI transfer time, plus 1 WRITE cycle.
- **`mem_write_enable` spacing:** never high on two consecutive cycles.

## Configuration
- `SPI_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` (8 bits): the sum modulo 256 of all bytes written.
  - Cleared when a request is latched; updated in WRITE; valid when `done` pulses.
- Undefined: the `checksum` port is absent and no adder is built.

## Test plan
- **Idle pass-through.** `cpu_spi_start = 1`, `cpu_spi_tx = 0xA5`, `cpu_spi_cs = 0` → `spi_start = 1`, `spi_data_tx = 0xA5`, `spi_cs = 0` in the same cycle; `busy = 0`.
- **Basic load.** `start` with `flash_address = 0x012345`, `length = 4`, `mem_base = 0x1000`, flash model returning 0x10..0x13:
  - MOSI bytes are 03 01 23 45 00 00 00 00.
  - Writes land at 0x1000..0x1003 with data 0x10..0x13, then CS rises and `done` pulses once.
  - With `SPI_LOADER_CHECKSUM_EN`, `checksum = 0x46`.
- **Deferral.** `start` while a CPU byte is in flight (`spi_busy = 1`) → CS stays high until `spi_busy` falls; then the load proceeds normally. A CPU `cpu_spi_start` during the load does not reach `spi_start`.
- **Zero length.** `length = 0` → `done` pulses 2 cycles after `start`, `spi_cs` stays 1, no `mem_write_enable`.
- **Progress and wrap.** `length = 0x0300`, `mem_base = 0xFF80` → `load_count` steps 1, 2, 3; the last address is `0x027F` (wrapped).
- **Reset mid-load.** `reset` during ADDR1 → next cycle `busy = 0`, `spi_cs = 1`, `spi_start = 0`, `load_count = 0`; a new `start` then completes normally.
